// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin four-phase arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        RTZ  = 2'd3
    } arb_state_t;

    localparam int N_REQ_DEFAULT       = 4;
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous bit; clears to 0 on reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_p <= '0;
        end else begin
            chain_p <= {chain_p[STAGES-2:0], d};
        end
    end

    assign q = chain_p[STAGES-1];

endmodule

// File: rtl/arbiter_rr_sync.sv
// Round-robin arbiter granting one of N_REQ asynchronous four-phase requesters
// access to a shared resource that also uses a four-phase handshake.
module arbiter_rr_sync
    import arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_in,
    output logic [N_REQ-1:0]         ack_in,
    output logic                     req_out,
    input  logic                     ack_out,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic                     busy
);

    localparam int SEL_W = $clog2(N_REQ);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [N_REQ-1:0] req_s;
    logic             ack_s;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] next_ptr;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req_sync
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (req_in[i]),
            .q   (req_s[i])
        );
    end

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_out),
        .q   (ack_s)
    );

    // First high request at or above p, wrapping; only consulted when r != 0.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [SEL_W-1:0] p);
        logic             found;
        logic [SEL_W-1:0] w;
        int               idx;
        found = 1'b0;
        w     = p;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = SEL_W'(idx);
            end
        end
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] g);
        logic [N_REQ-1:0] oh;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (int'(g) == i);
        end
        return oh;
    endfunction

    always_comb begin
        winner   = rr_pick(req_s, ptr);
        next_ptr = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req_out <= 1'b0;
            ack_in  <= '0;
            sel     <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_s) begin
                        sel     <= winner;
                        req_out <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        ack_in <= onehot(sel);
                        state  <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s[sel]) begin
                        req_out <= 1'b0;
                        state   <= RTZ;
                    end
                end
                RTZ: begin
                    // Pointer advances only once the resource has fully returned to zero.
                    if (!ack_s) begin
                        ack_in <= '0;
                        ptr    <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
